// File: rtl/muldiv_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// muldiv_pkg : shared encodings and constants for the sequential mul/div unit
// Rev 1.0
// ----------------------------------------------------------------------------
package muldiv_pkg;

  localparam int ITER  = 32;
  localparam int CNT_W = $clog2(ITER);

  typedef enum logic [2:0] {
    OP_MUL   = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ----------------------------------------------------------------------------
// muldiv_step : one combinational iteration (shift-add multiply or
//               non-restoring divide) on the shared {upper,low} work register
// Rev 1.0
// ----------------------------------------------------------------------------
module muldiv_step (
  input  logic        is_div_i,
  input  logic [32:0] upper_i,
  input  logic [31:0] low_i,
  input  logic [31:0] opnd_i,
  output logic [32:0] upper_o,
  output logic [31:0] low_o
);

  logic [32:0] w_sum;
  logic [32:0] w_shl;
  logic [32:0] w_rem;

  // Remainder arithmetic is modulo 2^33; the true value always fits, so the sign bit is exact.
  always_comb begin
    w_sum = upper_i + (low_i[0] ? {1'b0, opnd_i} : 33'd0);
    w_shl = {upper_i[31:0], low_i[31]};
    w_rem = upper_i[32] ? (w_shl + {1'b0, opnd_i}) : (w_shl - {1'b0, opnd_i});
    if (is_div_i) begin
      upper_o = w_rem;
      low_o   = {low_i[30:0], ~w_rem[32]};
    end else begin
      upper_o = {1'b0, w_sum[32:1]};
      low_o   = {w_sum[0], low_i[31:1]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// muldiv_seq : 32-iteration sequential multiplier/divider with HI/LO registers
// Rev 1.0
// ----------------------------------------------------------------------------
module muldiv_seq
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [31:0] muldata_o
);

  state_e             state_q;
  op_e                op_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               sign_a_q;
  logic               sign_b_q;
  logic [32:0]        upper_q;
  logic [31:0]        low_q;
  logic [31:0]        opnd_q;
  logic               done_q;
  logic [31:0]        hi_q;
  logic [31:0]        lo_q;
  logic [31:0]        muldata_q;

  logic               w_in_iter;
  logic               w_in_div;
  logic               w_in_signed;
  logic [31:0]        w_mag_a;
  logic [31:0]        w_mag_b;
  logic               w_is_div;
  logic [32:0]        w_step_upper;
  logic [31:0]        w_step_low;

  logic [63:0]        w_prod;
  logic [63:0]        w_prod_s;
  logic [31:0]        w_rem;
  logic [31:0]        w_rem_s;
  logic [31:0]        w_quo_s;
  logic [31:0]        hi_d;
  logic [31:0]        lo_d;
  logic [31:0]        muldata_d;

  assign w_in_iter   = (op_i == OP_MUL) || (op_i == OP_MULTU) ||
                       (op_i == OP_DIV) || (op_i == OP_DIVU);
  assign w_in_div    = (op_i == OP_DIV) || (op_i == OP_DIVU);
  assign w_in_signed = (op_i == OP_MUL) || (op_i == OP_DIV);
  assign w_mag_a     = neg_if(a_i, w_in_signed & a_i[31]);
  assign w_mag_b     = neg_if(b_i, w_in_signed & b_i[31]);
  assign w_is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);

  muldiv_step u_step (
    .is_div_i (w_is_div),
    .upper_i  (upper_q),
    .low_i    (low_q),
    .opnd_i   (opnd_q),
    .upper_o  (w_step_upper),
    .low_o    (w_step_low)
  );

  // Result formation; a zero divisor forces an all-ones quotient while the
  // remainder path naturally yields the original dividend.
  always_comb begin
    w_prod    = {upper_q[31:0], low_q};
    w_prod_s  = (sign_a_q ^ sign_b_q) ? (~w_prod + 64'd1) : w_prod;
    w_rem     = upper_q[32] ? (upper_q[31:0] + opnd_q) : upper_q[31:0];
    w_rem_s   = neg_if(w_rem, sign_a_q);
    w_quo_s   = (opnd_q == 32'd0) ? 32'hFFFF_FFFF : neg_if(low_q, sign_a_q ^ sign_b_q);
    hi_d      = hi_q;
    lo_d      = lo_q;
    muldata_d = muldata_q;
    case (op_q)
      OP_MUL:   muldata_d = w_prod_s[31:0];
      OP_MULTU: {hi_d, lo_d} = w_prod_s;
      OP_DIV,
      OP_DIVU: begin
        hi_d = w_rem_s;
        lo_d = w_quo_s;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= OP_MUL;
      cnt_q     <= '0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      upper_q   <= '0;
      low_q     <= '0;
      opnd_q    <= '0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      muldata_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (w_in_iter) begin
              op_q     <= op_e'(op_i);
              sign_a_q <= w_in_signed & a_i[31];
              sign_b_q <= w_in_signed & b_i[31];
              cnt_q    <= '0;
              upper_q  <= '0;
              // Divide shifts the dividend out of low; multiply shifts the multiplier.
              low_q    <= w_in_div ? w_mag_a : w_mag_b;
              opnd_q   <= w_in_div ? w_mag_b : w_mag_a;
              state_q  <= RUN;
            end else if (op_i == OP_MTHI) begin
              hi_q <= a_i;
            end else if (op_i == OP_MTLO) begin
              lo_q <= a_i;
            end
          end
        end
        RUN: begin
          upper_q <= w_step_upper;
          low_q   <= w_step_low;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ITER - 1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          hi_q      <= hi_d;
          lo_q      <= lo_d;
          muldata_q <= muldata_d;
          done_q    <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o    = (state_q != IDLE);
  assign done_o    = done_q;
  assign hi_o      = hi_q;
  assign lo_o      = lo_q;
  assign muldata_o = muldata_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_muldiv_seq : scoreboard bench for muldiv_seq
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] muldata;

  muldiv_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start),
    .op_i      (op),
    .a_i       (a),
    .b_i       (b),
    .busy_o    (busy),
    .done_o    (done),
    .hi_o      (hi),
    .lo_o      (lo),
    .muldata_o (muldata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [31:0] m_md = '0;
  int          n_chk  = 0;
  int          n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model: architectural effect of one operation on HI/LO/muldata.
  task automatic push_exp(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sp;
    logic [63:0] up;
    int          sx;
    int          sy;
    sx = x;
    sy = y;
    case (o)
      3'd0: begin
        sp   = longint'(sx) * longint'(sy);
        m_md = sp[31:0];
      end
      3'd1: begin
        up   = {32'd0, x} * {32'd0, y};
        m_hi = up[63:32];
        m_lo = up[31:0];
      end
      3'd2: begin
        if (y == 32'd0) begin
          m_lo = 32'hFFFF_FFFF; m_hi = x;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          m_lo = 32'h8000_0000; m_hi = 32'd0;
        end else begin
          m_lo = sx / sy; m_hi = sx % sy;
        end
      end
      default: begin
        if (y == 32'd0) begin
          m_lo = 32'hFFFF_FFFF; m_hi = x;
        end else begin
          m_lo = x / y; m_hi = x % y;
        end
      end
    endcase
    sb_q.push_back('{hi: m_hi, lo: m_lo, md: m_md});
  endtask

  // Drive one start strobe; called #1 after a rising edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    if (o <= 3'd3) push_exp(o, x, y);
    else if (o == 3'd4) m_hi = x;
    else if (o == 3'd5) m_lo = x;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom;
    if (o <= 3'd3) begin
      check_eq("busy_after_accept", {31'd0, busy}, 32'd1);
      check_eq("done_low_after_accept", {31'd0, done}, 32'd0);
    end
  endtask

  task automatic wait_done(input int poke_at);
    int   lat;
    exp_t e;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c == poke_at) begin
        start = 1'b1; op = 3'd1; a = $urandom; b = $urandom;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        lat = c;
        break;
      end
    end
    check_eq("latency", 32'(lat), 32'd33);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (lat != 0) begin
        check_eq("busy_in_done", {31'd0, busy}, 32'd0);
        check_eq("hi", hi, e.hi);
        check_eq("lo", lo, e.lo);
        check_eq("muldata", muldata, e.md);
      end
    end
  endtask

  initial begin
    int seen;
    logic [2:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_hi", hi, 32'd0);
    check_eq("rst_lo", lo, 32'd0);
    check_eq("rst_muldata", muldata, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;

    // First start lands on the first edge after reset release.
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(0);
    check_eq("multu_max_hi", hi, 32'hFFFF_FFFE);
    check_eq("multu_max_lo", lo, 32'h0000_0001);
    @(posedge clk); #1;
    check_eq("done_pulse_width", {31'd0, done}, 32'd0);

    issue(3'd0, 32'hFFFF_FFF9, 32'd6);
    wait_done(0);
    check_eq("mul_neg", muldata, 32'hFFFF_FFD6);

    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done(0);
    issue(3'd3, 32'd7, 32'd0);
    wait_done(0);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(0);
    issue(3'd2, 32'hFFFF_FFF9, 32'd0);
    wait_done(0);

    // Start while busy must be ignored; the done-cycle start must be taken.
    issue(3'd3, 32'd1000, 32'd7);
    wait_done(10);
    issue(3'd1, 32'd12345, 32'd678);
    wait_done(0);
    @(posedge clk); #1;

    issue(3'd4, 32'h1234_5678, 32'd0);
    check_eq("mthi_hi", hi, 32'h1234_5678);
    check_eq("mthi_busy", {31'd0, busy}, 32'd0);
    check_eq("mthi_done", {31'd0, done}, 32'd0);
    issue(3'd5, 32'hCAFE_F00D, 32'd0);
    check_eq("mtlo_lo", lo, 32'hCAFE_F00D);
    check_eq("mtlo_hi_kept", hi, 32'h1234_5678);
    issue(3'd6, 32'hDEAD_BEEF, 32'd3);
    check_eq("inv_busy", {31'd0, busy}, 32'd0);
    check_eq("inv_hi", hi, m_hi);
    check_eq("inv_lo", lo, m_lo);
    issue(3'd7, 32'hDEAD_BEEF, 32'd3);
    check_eq("inv7_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i % 5 == 4) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      if (i % 4 == 1) ra = -ra;
      issue(ro, ra, rb);
      wait_done(0);
    end

    // Abort a MULTU at cycle 15 with an asynchronous reset pulse.
    issue(3'd1, 32'h0F0F_0F0F, 32'h7777_7777);
    repeat (14) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort_hi", hi, 32'd0);
    check_eq("abort_lo", lo, 32'd0);
    check_eq("abort_muldata", muldata, 32'd0);
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb_q.delete();
    m_hi = '0; m_lo = '0; m_md = '0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    check_eq("abort_no_done", 32'(seen), 32'd0);
    check_eq("abort_hi_kept", hi, 32'd0);

    issue(3'd2, 32'd100, 32'hFFFF_FFF9);
    wait_done(0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameters: none; iteration count fixed at 32 (package constant ITER).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  reset: one clock; reset is asynchronous and active-low.
REQ-004 start  input  1  request strobe, sampled on rising clk edge.
REQ-005 op  input  3  MUL=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; codes 6-7 invalid.
REQ-006 a  input  32  rs operand / dividend / MTHI-MTLO source.
REQ-007 b  input  32  rt operand / divisor.
REQ-008 busy  output  1  high while an iterative operation is in progress.
REQ-009 done  output  1  one-cycle pulse on completion of MUL/MULTU/DIV/DIVU.
REQ-010 hi  output  32  architectural HI register.
REQ-011 lo  output  32  architectural LO register.
REQ-012 muldata  output  32  low 32 bits of last signed MUL product.

Function
REQ-013 FSM states IDLE, RUN, FIX; busy = (state != IDLE).
REQ-014 In IDLE, start=1 with op in 0-3 latches a, b, op and operand signs, clears iteration counter, enters RUN.
REQ-015 start while busy, and start with op 6-7, are ignored with no state change.
REQ-016 MTHI/MTLO in IDLE write a into hi/lo at the same edge; no busy, no done.
REQ-017 RUN performs one iteration per cycle for exactly 32 cycles, counter 0..31, then enters FIX.
REQ-018 MUL/DIV iterate on magnitudes (two's-complement negate of negative operands); MULTU/DIVU on raw operands.
REQ-019 Multiply iteration: shift-add, 64-bit accumulator, one multiplier bit per cycle LSB first.
REQ-020 Divide iteration: non-restoring, 33-bit partial remainder, one quotient bit per cycle MSB first.
REQ-021 FIX: final remainder correction (add divisor if negative), sign fix-up, register write, return to IDLE.
REQ-022 Sign rules: product negated if sign(a)^sign(b); quotient negated if sign(a)^sign(b); remainder takes sign of a.
REQ-023 At the FIX edge: MUL writes muldata=product[31:0], hi/lo unchanged; MULTU writes {hi,lo}=product; DIV/DIVU write lo=quotient, hi=remainder.
REQ-024 done=1 for exactly the cycle after the FIX edge; busy is 0 in that cycle; start accepted in that same cycle.
REQ-025 Latency: done asserted 33 cycles after the accepting edge (32 RUN + 1 FIX).
REQ-026 Divide by zero (DIVU or DIV, b=0): lo=32'hFFFFFFFF, hi=a; normal 33-cycle timing; no exception output.
REQ-027 DIV 32'h80000000 / 32'hFFFFFFFF: lo=32'h80000000, hi=0 (wraps, no trap).
REQ-028 hi/lo/muldata hold value between writes; inputs a/b may change after the accepting edge without effect.

Reset
REQ-029 rst_n low asynchronously forces state=IDLE, busy=0, done=0, hi=0, lo=0, muldata=0, counter=0.
REQ-030 Reset mid-RUN/FIX aborts the operation; no partial result reaches hi/lo/muldata.
REQ-031 First start is accepted on the first rising edge after rst_n deasserts.

Structure
REQ-032 Package muldiv_pkg holds op encoding enum, FSM state enum, ITER=32.
REQ-033 One sub-module muldiv_step: combinational single iteration (shift-add or add/sub select) instanced once; FSM, counter, sign handling and HI/LO registers stay in muldiv_seq.

Verification
REQ-034 MULTU a=32'hFFFFFFFF b=32'hFFFFFFFF -> after 33 cycles done=1, hi=32'hFFFFFFFE, lo=32'h00000001.
REQ-035 MUL a=-7 b=6 -> muldata=32'hFFFFFFD6 (-42), hi/lo unchanged.
REQ-036 DIV a=-7 b=2 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1); DIVU a=7 b=0 -> lo=32'hFFFFFFFF, hi=7.
REQ-037 start DIVU at cycle 0, second start at cycle 10 -> second ignored, single done at cycle 33; start in done cycle accepted.
REQ-038 MTHI a=32'h12345678 in IDLE -> hi=32'h12345678 next cycle, busy=0, done=0; rst_n pulse at cycle 15 of a MULTU -> hi=lo=0, no done.
